// File: rtl/nco_sweep_ctrl_pkg.sv
// Shared types for the NCO phase-increment sweep controller.
// Holds the FSM state encoding used by the top level.
package nco_sweep_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DWN  = 2'd2,
        DONE = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// Control and status bundle between a sweep requester and the sweep controller.
// The master side issues requests and parameters; the slave side drives the NCO increment and status.
interface nco_sweep_ctrl_if #(
    parameter int APR     = 16,
    parameter int DWELL_W = 16
);
    logic               start_i;
    logic               abort_i;
    logic [APR-1:0]     f_start_i;
    logic [APR-1:0]     f_stop_i;
    logic [APR-1:0]     f_step_i;
    logic [DWELL_W-1:0] dwell_i;
    logic               updown_i;
    logic               repeat_i;
    logic [APR-1:0]     phi_inc_o;
    logic               busy_o;
    logic               done_o;

    modport master (
        output start_i, abort_i, f_start_i, f_stop_i, f_step_i, dwell_i, updown_i, repeat_i,
        input  phi_inc_o, busy_o, done_o
    );

    modport slave (
        input  start_i, abort_i, f_start_i, f_stop_i, f_step_i, dwell_i, updown_i, repeat_i,
        output phi_inc_o, busy_o, done_o
    );
endinterface

// File: rtl/nco_sweep_ctrl_dwell_cnt.sv
// Loadable dwell down-counter; expire is high while the count sits at zero.
// Loading takes priority over counting; everything freezes while clken is low.
module nco_sweep_dwell_cnt #(
    parameter int DWELL_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clken,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_load_val,
    output logic               o_expire
);
    logic [DWELL_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clken) begin
            if (i_load) begin
                r_cnt <= i_load_val;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - DWELL_W'(1);
            end
        end
    end

    assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Stepped linear chirp generator feeding the NCO phase increment.
// Ramps f_start -> f_stop (optionally back down) with a programmable dwell per step.
module nco_sweep_ctrl
    import nco_sweep_pkg::*;
#(
    parameter int APR     = 16,
    parameter int DWELL_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,
    nco_sweep_ctrl_if.slave   bus
);
    sweep_state_t       r_state, w_state_nxt;
    logic [APR-1:0]     r_phi, w_phi_nxt;
    logic               r_busy, w_busy_nxt;
    logic [APR-1:0]     r_fstart, r_fstop, r_fstep;
    logic [DWELL_W-1:0] r_dwell, w_load_val;
    logic               r_updown, r_repeat, r_degen;
    logic               w_load, w_latch, w_expire;
    logic [APR-1:0]     w_up_phi, w_dn_phi;

    // Saturating step towards an upper limit, formed one bit wider so it cannot wrap.
    function automatic logic [APR-1:0] sat_add(input logic [APR-1:0] a, input logic [APR-1:0] b,
                                               input logic [APR-1:0] lim);
        logic [APR:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, lim}) return lim;
        return s[APR-1:0];
    endfunction

    // Saturating step towards a lower limit; the extra MSB flags a borrow.
    function automatic logic [APR-1:0] sat_sub(input logic [APR-1:0] a, input logic [APR-1:0] b,
                                               input logic [APR-1:0] lim);
        logic [APR:0] s;
        s = {1'b0, a} - {1'b0, b};
        if (s[APR] || (s[APR-1:0] < lim)) return lim;
        return s[APR-1:0];
    endfunction

    assign w_up_phi = sat_add(r_phi, r_fstep, r_fstop);
    assign w_dn_phi = sat_sub(r_phi, r_fstep, r_fstart);

    nco_sweep_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_clken    (clken),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_phi_nxt   = r_phi;
        w_busy_nxt  = r_busy;
        w_load      = 1'b0;
        w_load_val  = r_dwell;
        w_latch     = 1'b0;
        if (bus.abort_i) begin
            w_state_nxt = IDLE;
            w_phi_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_load      = 1'b1;
            w_load_val  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start_i) begin
                        w_state_nxt = UP;
                        w_phi_nxt   = bus.f_start_i;
                        w_busy_nxt  = 1'b1;
                        w_load      = 1'b1;
                        w_load_val  = bus.dwell_i;
                        w_latch     = 1'b1;
                    end
                end
                UP: begin
                    if (w_expire) begin
                        w_load = 1'b1;
                        if (r_degen || (r_phi == r_fstop)) begin
                            if (r_updown && !r_degen) begin
                                w_state_nxt = DWN;
                                w_phi_nxt   = w_dn_phi;
                            end else begin
                                w_state_nxt = DONE;
                            end
                        end else begin
                            w_phi_nxt = w_up_phi;
                        end
                    end
                end
                DWN: begin
                    if (w_expire) begin
                        w_load = 1'b1;
                        if (r_phi == r_fstart) begin
                            w_state_nxt = DONE;
                        end else begin
                            w_phi_nxt = w_dn_phi;
                        end
                    end
                end
                DONE: begin
                    if (r_repeat) begin
                        w_state_nxt = UP;
                        w_phi_nxt   = r_fstart;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_busy_nxt  = 1'b0;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_phi   <= '0;
            r_busy  <= 1'b0;
        end else if (clken) begin
            r_state <= w_state_nxt;
            r_phi   <= w_phi_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Sweep parameters captured only when a start is accepted.
    always_ff @(posedge clk) begin
        if (clken && w_latch) begin
            r_fstart <= bus.f_start_i;
            r_fstop  <= bus.f_stop_i;
            r_fstep  <= bus.f_step_i;
            r_dwell  <= bus.dwell_i;
            r_updown <= bus.updown_i;
            r_repeat <= bus.repeat_i;
            r_degen  <= (bus.f_step_i == '0) || (bus.f_start_i >= bus.f_stop_i);
        end
    end

    assign bus.phi_inc_o = r_phi;
    assign bus.busy_o    = r_busy;
    assign bus.done_o    = (r_state == DONE) && clken && !bus.abort_i;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: directed chirp cases plus randomized sweeps
// compared against a precomputed per-step trace of expected outputs.
module tb_nco_sweep_ctrl;
    localparam int APR     = 16;
    localparam int DWELL_W = 16;

    logic clk = 1'b0;
    logic reset;
    logic clken;

    always #5 clk = ~clk;

    nco_sweep_ctrl_if #(.APR(APR), .DWELL_W(DWELL_W)) bus();

    nco_sweep_ctrl #(.APR(APR), .DWELL_W(DWELL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .clken (clken),
        .bus   (bus.slave)
    );

    typedef struct {
        int phi;
        bit busy;
        bit done;
    } exp_t;

    exp_t trace[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_outs(input string tag, input int phi, input bit busy, input bit done);
        check({tag, "_phi"},  32'(bus.phi_inc_o), 32'(phi));
        check({tag, "_busy"}, 32'(bus.busy_o),    32'(busy));
        check({tag, "_done"}, 32'(bus.done_o),    32'(done));
    endtask

    // Expected enabled-cycle trace for the given number of passes, derived from the sweep rules.
    task automatic build_trace(input int fs, input int fe, input int st, input int dw,
                               input bit ud, input int passes);
        int   vals[$];
        int   v;
        exp_t e;
        trace.delete();
        vals.delete();
        vals.push_back(fs);
        if (st != 0 && fs < fe) begin
            v = fs;
            while (v < fe) begin
                v = (v + st > fe) ? fe : v + st;
                vals.push_back(v);
            end
            if (ud) begin
                while (v > fs) begin
                    v = (v - st < fs) ? fs : v - st;
                    vals.push_back(v);
                end
            end
        end
        for (int p = 0; p < passes; p++) begin
            foreach (vals[i]) begin
                for (int d = 0; d <= dw; d++) begin
                    e.phi = vals[i]; e.busy = 1'b1; e.done = 1'b0;
                    trace.push_back(e);
                end
            end
            e.phi = vals[vals.size()-1]; e.busy = 1'b1; e.done = 1'b1;
            trace.push_back(e);
        end
    endtask

    // gate: 0 = clken always high, 1 = toggling, 2 = random.
    task automatic run_sweep(input string tag, input int fs, input int fe, input int st,
                             input int dw, input bit ud, input bit rp, input int passes,
                             input int gate, input bit noise);
        int idx;
        bit ce;
        bit tog;
        int last;
        build_trace(fs, fe, st, dw, ud, passes);
        last = trace[trace.size()-1].phi;
        bus.f_start_i = 16'(fs);
        bus.f_stop_i  = 16'(fe);
        bus.f_step_i  = 16'(st);
        bus.dwell_i   = 16'(dw);
        bus.updown_i  = ud;
        bus.repeat_i  = rp;
        bus.abort_i   = 1'b0;
        bus.start_i   = 1'b1;
        clken         = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        idx = 0;
        tog = 1'b0;
        while (idx < trace.size()) begin
            ce = (gate == 0) ? 1'b1 : (gate == 1) ? tog : 1'($urandom_range(0, 1));
            tog = ~tog;
            clken = ce;
            if (noise) begin
                bus.f_start_i = 16'($urandom);
                bus.f_stop_i  = 16'($urandom);
                bus.f_step_i  = 16'($urandom_range(0, 300));
                bus.dwell_i   = 16'($urandom_range(0, 5));
                bus.updown_i  = 1'($urandom_range(0, 1));
                bus.repeat_i  = 1'($urandom_range(0, 1));
                bus.start_i   = ($urandom_range(0, 3) == 0);
            end
            #2;
            check_outs(tag, trace[idx].phi, trace[idx].busy, trace[idx].done & ce);
            @(posedge clk); #1;
            if (ce) idx++;
        end
        bus.start_i = 1'b0;
        clken = 1'b1;
        if (!rp) begin
            #2;
            check_outs({tag, "_idle"}, last, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    task automatic abort_check(input string tag);
        bus.abort_i = 1'b1;
        bus.start_i = 1'b1;
        clken = 1'b1;
        #2;
        check({tag, "_done_in_abort"}, 32'(bus.done_o), 32'd0);
        @(posedge clk); #1;
        bus.abort_i = 1'b0;
        bus.start_i = 1'b0;
        #2;
        check_outs({tag, "_abort"}, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_outs({tag, "_abort_hold"}, 0, 1'b0, 1'b0);
    endtask

    task automatic reset_check(input string tag);
        reset = 1'b1;
        clken = 1'b0;
        @(posedge clk); #1;
        check_outs(tag, 0, 1'b0, 1'b0);
        reset = 1'b0;
        clken = 1'b1;
        #2;
        check_outs({tag, "_post"}, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        int fs, fe, st, dw, span;
        bit ud, rp;
        reset = 1'b1;
        clken = 1'b0;
        bus.start_i = 1'b0; bus.abort_i = 1'b0;
        bus.f_start_i = '0; bus.f_stop_i = '0; bus.f_step_i = '0; bus.dwell_i = '0;
        bus.updown_i = 1'b0; bus.repeat_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        clken = 1'b1;
        #2;
        check_outs("reset", 0, 1'b0, 1'b0);
        @(posedge clk); #1;

        run_sweep("basic_up",  100, 130, 10, 1, 1'b0, 1'b0, 1, 0, 1'b0);
        run_sweep("updown",    0, 25, 10, 0, 1'b1, 1'b0, 1, 0, 1'b0);
        run_sweep("near_wrap", 16'hFFF0, 16'hFFFF, 16'h10, 0, 1'b0, 1'b0, 1, 0, 1'b0);
        run_sweep("gated",     100, 130, 10, 1, 1'b0, 1'b0, 1, 1, 1'b0);
        run_sweep("busy_start", 200, 260, 7, 2, 1'b1, 1'b0, 1, 0, 1'b1);
        run_sweep("pre_abort", 300, 400, 9, 1, 1'b1, 1'b1, 1, 0, 1'b0);
        abort_check("abort");
        run_sweep("degen_ge",  90, 40, 5, 1, 1'b1, 1'b0, 1, 0, 1'b0);
        run_sweep("rpt_step0", 50, 80, 0, 2, 1'b0, 1'b1, 3, 0, 1'b0);
        reset_check("mid_reset");

        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                fe = 65535;
                fs = 65535 - int'($urandom_range(0, 40));
            end else begin
                fs = int'($urandom_range(0, 65535));
                span = int'($urandom_range(0, 60));
                fe = ($urandom_range(0, 5) == 0) ? fs - span : fs + span;
                if (fe > 65535) fe = 65535;
                if (fe < 0) fe = 0;
            end
            st = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 20));
            dw = int'($urandom_range(0, 3));
            ud = 1'($urandom_range(0, 1));
            rp = ($urandom_range(0, 3) == 0);
            run_sweep($sformatf("rand%0d", it), fs, fe, st, dw, ud, rp, rp ? 2 : 1,
                      int'($urandom_range(0, 2)), 1'b1);
            if (rp) abort_check($sformatf("rand%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
